branch_predict_resolve: RTL and testbench

- Parametrised successor to the single-cycle branch comparator.
- Resolves RV32I conditional branches (BEQ/BNE/BLT/BGE/BLTU/BGEU) and selects the next PC.
- Adds a direct-mapped branch history table (BHT) of 2-bit saturating counters, so fetch can get a taken/not-taken prediction.
- Flags mispredictions and keeps saturating performance counters. Sits between execute (comparator operands, target adder) and the PC register / fetch.

---
 rtl/branch_predict_resolve.sv | 95 +++++++++
 tb/tb_branch_predict_resolve.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/branch_predict_resolve.sv
// RV32I conditional branch resolution with a direct-mapped 2-bit BHT and
// saturating branch / mispredict performance counters.
module branch_predict_resolve #(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned BHT_ENTRIES = 64,
  parameter int unsigned IDX_LSB     = 2,
  parameter logic [1:0]  CTR_INIT    = 2'b01,
  parameter int unsigned PERF_W      = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [XLEN-1:0]   fetch_pc,
  output logic              fetch_pred_taken,
  input  logic              ex_valid,
  input  logic              ex_branch,
  input  logic [2:0]        ex_branchtype,
  input  logic [XLEN-1:0]   ex_pc,
  input  logic [XLEN-1:0]   ex_pc_plus4,
  input  logic [XLEN-1:0]   ex_target,
  input  logic              ex_pred_taken,
  input  logic [XLEN-1:0]   in1,
  input  logic [XLEN-1:0]   in2,
  output logic [XLEN-1:0]   pc_next,
  output logic              actual_taken,
  output logic              mispredict,
  output logic [PERF_W-1:0] branch_count,
  output logic [PERF_W-1:0] mispredict_count
);

  localparam int unsigned IDX_W = $clog2(BHT_ENTRIES);

  logic [1:0]       bht [BHT_ENTRIES];
  logic [IDX_W-1:0] fetch_idx;
  logic [IDX_W-1:0] ex_idx;
  logic [1:0]       ex_ctr;
  logic             qualify;
  logic             cmp;
  logic             unused_pc_bits;

  assign fetch_idx      = fetch_pc[IDX_LSB +: IDX_W];
  assign ex_idx         = ex_pc[IDX_LSB +: IDX_W];
  assign ex_ctr         = bht[ex_idx];
  assign unused_pc_bits = ^{fetch_pc, ex_pc};

  // Raw comparator outcome; illegal encodings never take.
  always_comb begin
    cmp = 1'b0;
    case (ex_branchtype)
      3'b000:  cmp = (in1 == in2);
      3'b001:  cmp = (in1 != in2);
      3'b010:  cmp = ($signed(in1) <  $signed(in2));
      3'b011:  cmp = ($signed(in1) >= $signed(in2));
      3'b100:  cmp = (in1 <  in2);
      3'b101:  cmp = (in1 >= in2);
      default: cmp = 1'b0;
    endcase
  end

  assign qualify          = ex_valid & ex_branch & (ex_branchtype <= 3'b101);
  assign actual_taken     = qualify & cmp;
  assign pc_next          = actual_taken ? ex_target : ex_pc_plus4;
  assign mispredict       = qualify & (ex_pred_taken != actual_taken);
  assign fetch_pred_taken = bht[fetch_idx][1];

  // Saturating counter update; reset clears every entry in a single edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(BHT_ENTRIES); i++) begin
        bht[i] <= CTR_INIT;
      end
    end else if (qualify) begin
      if (actual_taken && (ex_ctr != 2'b11)) begin
        bht[ex_idx] <= ex_ctr + 2'd1;
      end else if (!actual_taken && (ex_ctr != 2'b00)) begin
        bht[ex_idx] <= ex_ctr - 2'd1;
      end
    end
  end

  // Performance counters stick at all-ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      branch_count     <= '0;
      mispredict_count <= '0;
    end else begin
      if (qualify && (branch_count != '1)) begin
        branch_count <= branch_count + PERF_W'(1);
      end
      if (mispredict && (mispredict_count != '1)) begin
        mispredict_count <= mispredict_count + PERF_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_branch_predict_resolve.sv
// Bench for branch_predict_resolve: directed steps plus a randomized phase
// against a behavioural model; a PERF_W=4 copy checks counter saturation.
module tb_branch_predict_resolve;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] fetch_pc;
  logic        fetch_pred_taken, fetch_pred_taken4;
  logic        ex_valid, ex_branch, ex_pred_taken;
  logic [2:0]  ex_branchtype;
  logic [31:0] ex_pc, ex_pc_plus4, ex_target, in1, in2;
  logic [31:0] pc_next, pc_next4;
  logic        actual_taken, actual_taken4, mispredict, mispredict4;
  logic [31:0] branch_count, mispredict_count;
  logic [3:0]  branch_count4, mispredict_count4;

  int    checks = 0;
  int    errors = 0;
  int    ctr [64];
  longint bcnt, mcnt;

  always #5 clk = ~clk;

  branch_predict_resolve dut (
    .clk(clk), .rst(rst), .fetch_pc(fetch_pc), .fetch_pred_taken(fetch_pred_taken),
    .ex_valid(ex_valid), .ex_branch(ex_branch), .ex_branchtype(ex_branchtype),
    .ex_pc(ex_pc), .ex_pc_plus4(ex_pc_plus4), .ex_target(ex_target),
    .ex_pred_taken(ex_pred_taken), .in1(in1), .in2(in2), .pc_next(pc_next),
    .actual_taken(actual_taken), .mispredict(mispredict),
    .branch_count(branch_count), .mispredict_count(mispredict_count)
  );

  branch_predict_resolve #(.PERF_W(4)) dut4 (
    .clk(clk), .rst(rst), .fetch_pc(fetch_pc), .fetch_pred_taken(fetch_pred_taken4),
    .ex_valid(ex_valid), .ex_branch(ex_branch), .ex_branchtype(ex_branchtype),
    .ex_pc(ex_pc), .ex_pc_plus4(ex_pc_plus4), .ex_target(ex_target),
    .ex_pred_taken(ex_pred_taken), .in1(in1), .in2(in2), .pc_next(pc_next4),
    .actual_taken(actual_taken4), .mispredict(mispredict4),
    .branch_count(branch_count4), .mispredict_count(mispredict_count4)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic longint sx(input logic [31:0] v);
    return v[31] ? longint'(v) - 64'sd4294967296 : longint'(v);
  endfunction

  function automatic bit model_taken(input logic [2:0] t, input logic [31:0] a, input logic [31:0] b);
    case (t)
      3'd0: return a == b;
      3'd1: return a != b;
      3'd2: return sx(a) <  sx(b);
      3'd3: return sx(a) >= sx(b);
      3'd4: return longint'(a) <  longint'(b);
      3'd5: return longint'(a) >= longint'(b);
      default: return 1'b0;
    endcase
  endfunction

  function automatic int bidx(input logic [31:0] pc);
    return int'((pc / 4) % 64);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 64; i++) ctr[i] = 1;
    bcnt = 0;
    mcnt = 0;
  endtask

  task automatic set_br(input logic v, input logic br, input logic [2:0] t, input logic [31:0] pc,
                        input logic [31:0] tgt, input logic pred, input logic [31:0] a,
                        input logic [31:0] b);
    ex_valid = v; ex_branch = br; ex_branchtype = t; ex_pc = pc; ex_pc_plus4 = pc + 32'd4;
    ex_target = tgt; ex_pred_taken = pred; in1 = a; in2 = b;
  endtask

  // One clock: check combinational outputs, advance the model, check registered state.
  task automatic cycle();
    bit q, t, mp;
    int fi, ei;
    q  = ex_valid && ex_branch && (ex_branchtype < 3'd6);
    t  = q && model_taken(ex_branchtype, in1, in2);
    mp = q && (ex_pred_taken != t);
    fi = bidx(fetch_pc);
    ei = bidx(ex_pc);
    #1;
    chk("actual_taken", 32'(actual_taken), 32'(t));
    chk("pc_next", pc_next, t ? ex_target : ex_pc_plus4);
    chk("mispredict", 32'(mispredict), 32'(mp));
    chk("fetch_pred", 32'(fetch_pred_taken), 32'(ctr[fi] >= 2));
    @(posedge clk);
    if (rst) model_reset();
    else if (q) begin
      ctr[ei] = t ? ((ctr[ei] < 3) ? ctr[ei] + 1 : 3) : ((ctr[ei] > 0) ? ctr[ei] - 1 : 0);
      bcnt++;
      if (mp) mcnt++;
    end
    #1;
    chk("branch_count", branch_count, 32'(bcnt));
    chk("mispredict_count", mispredict_count, 32'(mcnt));
    chk("branch_count4", 32'(branch_count4), 32'((bcnt > 15) ? 15 : bcnt));
    chk("mispredict_count4", 32'(mispredict_count4), 32'((mcnt > 15) ? 15 : mcnt));
  endtask

  initial begin
    fetch_pc = 32'h0;
    set_br(1'b0, 1'b0, 3'd0, 32'h100, 32'h0, 1'b0, 32'h0, 32'h0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    model_reset();
    rst = 1'b0;
    chk("reset_branch_count", branch_count, 32'h0);
    chk("reset_mispredict_count", mispredict_count, 32'h0);

    // Non-branch: sequential PC, no prediction anywhere
    set_br(1'b1, 1'b0, 3'd0, 32'h100, 32'h200, 1'b0, 32'h5, 32'h5);
    for (int i = 0; i < 4; i++) begin
      fetch_pc = 32'(i * 68);
      cycle();
      chk("nb_pc_next", pc_next, 32'h104);
      chk("nb_pred", 32'(fetch_pred_taken), 32'h0);
    end

    // Signed vs unsigned compare
    set_br(1'b1, 1'b1, 3'd2, 32'h100, 32'h200, 1'b0, 32'hFFFF_FFFF, 32'h1);
    cycle();
    chk("blt_pc_next", pc_next, 32'h200);
    set_br(1'b1, 1'b1, 3'd4, 32'h100, 32'h200, 1'b0, 32'hFFFF_FFFF, 32'h1);
    cycle();
    chk("bltu_pc_next", pc_next, 32'h104);

    // Taken BEQ at 0x40 four times, always predicted not-taken
    rst = 1'b1; cycle(); rst = 1'b0;
    fetch_pc = 32'h40;
    set_br(1'b1, 1'b1, 3'd0, 32'h40, 32'h300, 1'b0, 32'h7, 32'h7);
    for (int i = 0; i < 4; i++) begin
      cycle();
      chk("beq_pred_after_edge", 32'(fetch_pred_taken), 32'h1);
    end
    chk("beq_branch_count", branch_count, 32'd4);
    chk("beq_mispredict_count", mispredict_count, 32'd4);

    // Same-index hazard and aliasing
    fetch_pc = 32'h80;
    set_br(1'b1, 1'b1, 3'd1, 32'h80, 32'h400, 1'b0, 32'h1, 32'h2);
    #1 chk("hazard_pre", 32'(fetch_pred_taken), 32'h0);
    cycle();
    set_br(1'b0, 1'b1, 3'd0, 32'h80, 32'h400, 1'b0, 32'h1, 32'h1);
    #1 chk("hazard_post", 32'(fetch_pred_taken), 32'h1);
    fetch_pc = 32'h180;
    cycle();
    chk("alias_read", 32'(fetch_pred_taken), 32'h1);
    set_br(1'b1, 1'b1, 3'd0, 32'h180, 32'h400, 1'b1, 32'h3, 32'h4);
    fetch_pc = 32'h80;
    cycle();
    chk("alias_update", 32'(fetch_pred_taken), 32'h0);

    // Illegal type and invalid instruction leave everything alone
    set_br(1'b1, 1'b1, 3'd6, 32'h80, 32'h500, 1'b1, 32'h9, 32'h9);
    cycle();
    chk("illegal_pc_next", pc_next, 32'h84);
    set_br(1'b1, 1'b1, 3'd7, 32'h80, 32'h500, 1'b0, 32'h9, 32'h9);
    cycle();
    set_br(1'b0, 1'b1, 3'd0, 32'h80, 32'h500, 1'b1, 32'h9, 32'h9);
    cycle();
    chk("invalid_pc_next", pc_next, 32'h84);

    // Drive the 4-bit mispredict counter past its ceiling
    set_br(1'b1, 1'b1, 3'd0, 32'hC0, 32'h600, 1'b0, 32'h1, 32'h1);
    for (int i = 0; i < 20; i++) cycle();
    chk("sat4_mispredict", 32'(mispredict_count4), 32'hF);
    chk("sat4_branch", 32'(branch_count4), 32'hF);

    // Randomized traffic with occasional reset
    for (int i = 0; i < 400; i++) begin
      logic [31:0] a;
      a = $urandom;
      rst = ($urandom_range(0, 39) == 0);
      set_br(1'(($urandom_range(0, 7) != 0)), 1'(($urandom_range(0, 5) != 0)),
             3'($urandom_range(0, 7)),
             {$urandom_range(0, 3) == 0 ? 22'($urandom) : 22'h0, 4'($urandom_range(0, 15)), 6'h0} | 32'($urandom_range(0, 3) * 64'd16),
             $urandom, 1'($urandom), a, ($urandom_range(0, 3) == 0) ? a : $urandom);
      fetch_pc = ($urandom_range(0, 1) == 0) ? ex_pc : $urandom;
      cycle();
    end

    // Reset with a concurrent taken update wins; every entry back to init
    rst = 1'b1;
    set_br(1'b1, 1'b1, 3'd0, 32'h40, 32'h700, 1'b0, 32'h2, 32'h2);
    cycle();
    rst = 1'b0;
    ex_valid = 1'b0;
    chk("midreset_branch_count", branch_count, 32'h0);
    chk("midreset_mispredict_count", mispredict_count, 32'h0);
    for (int i = 0; i < 64; i++) begin
      fetch_pc = 32'(i * 4);
      cycle();
      chk("midreset_entry", 32'(fetch_pred_taken), 32'h0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
